boot_load_ctrl: RTL

- Sequences program loading and owns the shared instruction/data memory write port.
- On a load request: holds the CPU in reset, enables the UART word loader, and converts each loader word into a single-cycle memory write.
- Detects end-of-program by idle timeout or by the word limit, then hands the port back to the CPU and releases CPU reset.

---
 rtl/boot_load_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/boot_load_ctrl.sv
// Boot-load sequencer: holds the CPU in reset while a UART loader fills the shared memory.
// Optional macro BOOT_LOAD_CHECKSUM_EN adds load_sum, the running sum of written words.
module boot_load_ctrl #(
    parameter int MAX_WORDS    = 256,
    parameter int IDLE_TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        ldr_wr,
    input  logic [31:0] ldr_addr,
    input  logic [31:0] ldr_data,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic        ldr_enable,
    output logic        cpu_rst,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        busy,
    output logic [15:0] word_cnt,
`ifdef BOOT_LOAD_CHECKSUM_EN
    output logic [31:0] load_sum,
`endif
    output logic        addr_err
);

    localparam int                IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [31:0]       MAX_W     = 32'(MAX_WORDS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] { ST_RUN, ST_LOAD, ST_DONE } state_e;

    state_e            state_q;
    logic              load_req_q, ldr_wr_q;
    logic              cpu_rst_q, ldr_enable_q, addr_err_q;
    logic              wr_q;
    logic [31:0]       wr_addr_q, wr_data_q;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [IDLE_W-1:0] idle_q;
    logic              load_rise, word_evt, addr_ok, cnt_full, timed_out;

    assign load_rise  = load_req & ~load_req_q;
    assign word_evt   = ldr_wr & ~ldr_wr_q & (state_q == ST_LOAD);
    assign addr_ok    = ldr_addr < MAX_W;
    assign word_cnt_d = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
    assign cnt_full   = ({16'h0000, word_cnt_q} == MAX_W);
    assign timed_out  = (word_cnt_q != 16'd0) && (idle_q == IDLE_LAST);

`ifdef BOOT_LOAD_CHECKSUM_EN
    logic [31:0] sum_q;
    assign load_sum = sum_q;
`endif

    // NOTE: every register in a clocked block uses <=, so all reads see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            load_req_q   <= 1'b0;
            ldr_wr_q     <= 1'b0;
            cpu_rst_q    <= 1'b1;
            ldr_enable_q <= 1'b0;
            addr_err_q   <= 1'b0;
            wr_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_cnt_q   <= '0;
            idle_q       <= '0;
`ifdef BOOT_LOAD_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            load_req_q <= load_req;
            ldr_wr_q   <= ldr_wr;
            wr_q       <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    cpu_rst_q <= 1'b0;
                    if (load_rise) begin
                        state_q      <= ST_LOAD;
                        cpu_rst_q    <= 1'b1;
                        ldr_enable_q <= 1'b1;
                        word_cnt_q   <= '0;
                        addr_err_q   <= 1'b0;
                        idle_q       <= '0;
`ifdef BOOT_LOAD_CHECKSUM_EN
                        sum_q        <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    // A word event always wins: the count/timeout exits are evaluated on quiet cycles.
                    if (word_evt) begin
                        idle_q <= '0;
                        if (addr_ok) begin
                            wr_q       <= 1'b1;
                            wr_addr_q  <= ldr_addr;
                            wr_data_q  <= ldr_data;
                            word_cnt_q <= word_cnt_d;
`ifdef BOOT_LOAD_CHECKSUM_EN
                            sum_q      <= sum_q + ldr_data;
`endif
                        end else begin
                            addr_err_q <= 1'b1;
                        end
                    end else if (cnt_full || timed_out) begin
                        state_q      <= ST_DONE;
                        ldr_enable_q <= 1'b0;
                    end else if (word_cnt_q != 16'd0) begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_RUN;
                    cpu_rst_q <= 1'b0;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        mem_wr   = wr_q;
        mem_addr = wr_addr_q;
        mem_data = wr_data_q;
        if (state_q == ST_RUN) begin
            mem_wr   = cpu_wr;
            mem_addr = cpu_addr;
            mem_data = cpu_data;
        end
    end

    assign busy       = (state_q != ST_RUN);
    assign cpu_rst    = cpu_rst_q;
    assign ldr_enable = ldr_enable_q;
    assign word_cnt   = word_cnt_q;
    assign addr_err   = addr_err_q;

endmodule
